// File: rtl/result_drain_4x128.sv
// result_drain_4x128
//
// Output-side reader for the systolic array's 128-bit row bus (16 lanes of
// 8 bits). Rows strobed in with in_en land in a DEPTH-entry circular buffer
// and leave as BEATS = IN_W/OUT_W beats of OUT_W bits on a valid/ready
// stream. Beat 0 of a row is din[OUT_W-1:0] (lanes 0..3).
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   in_en     in   row strobe; din is captured on this edge
//   din       in   IN_W row data, lane k = din[8k+7:8k]
//   in_full   out  buffer holds DEPTH rows (advisory only)
//   overflow  out  sticky flag: a row was dropped; cleared only by reset
//   m_valid   out  a beat is presented on m_data
//   m_ready   in   consumer accepts the presented beat
//   m_data    out  OUT_W current beat, 0 when m_valid=0
//   m_last    out  final beat of a tile of ROWS_PER_TILE rows
//   count     out  rows currently stored, 0..DEPTH
//   m_parity  out  (only with RESULT_DRAIN_PARITY_EN) per-byte XOR of m_data
//
// Build option: define RESULT_DRAIN_PARITY_EN to add the m_parity output.
//
// Handshake: a beat transfers on every rising edge where m_valid and
// m_ready are both 1. Once m_valid is 1 it stays 1, with m_data and m_last
// held, until that beat transfers.
module result_drain_4x128 #(
    parameter int DEPTH         = 4,
    parameter int IN_W          = 128,
    parameter int OUT_W         = 32,
    parameter int ROWS_PER_TILE = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_en,
    input  logic [IN_W-1:0]              din,
    output logic                         in_full,
    output logic                         overflow,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [OUT_W-1:0]             m_data,
    output logic                         m_last,
`ifdef RESULT_DRAIN_PARITY_EN
    output logic [OUT_W/8-1:0]           m_parity,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int BEATS  = IN_W / OUT_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RC_W   = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [RC_W-1:0]   LAST_ROW  = RC_W'(ROWS_PER_TILE - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    logic [IN_W-1:0]   mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [RC_W-1:0]   row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              xfer;
    logic              pop_row;
    logic              push;
    logic              drop;
    logic [IN_W-1:0]   rd_row;
    logic [OUT_W-1:0]  beat_data;

    assign m_valid  = (count_q != '0);
    assign in_full  = (count_q == FULL_CNT);
    assign overflow = overflow_q;
    assign count    = count_q;

    assign xfer    = m_valid & m_ready;
    assign pop_row = xfer & (beat_q == LAST_BEAT);
    // A full buffer still takes a row when the head row leaves on the same edge.
    assign push    = in_en & (~in_full | pop_row);
    assign drop    = in_en & in_full & ~pop_row;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_d     = beat_q;
        row_cnt_d  = row_cnt_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (xfer) begin
            if (beat_q == LAST_BEAT) begin
                beat_d    = '0;
                rd_ptr_d  = rd_ptr_q + 1'b1;
                row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
        end

        case ({push, pop_row})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_q     <= '0;
            row_cnt_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_q     <= beat_d;
            row_cnt_q  <= row_cnt_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Row storage is deliberately not reset; the pointers and count alone
    // decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign rd_row = mem_q[rd_ptr_q];

    always_comb begin
        beat_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                beat_data = rd_row[b*OUT_W +: OUT_W];
            end
        end
    end

    assign m_data = m_valid ? beat_data : '0;
    assign m_last = m_valid & (beat_q == LAST_BEAT) & (row_cnt_q == LAST_ROW);

`ifdef RESULT_DRAIN_PARITY_EN
    // m_data is already forced to 0 when idle, so parity follows it to 0.
    always_comb begin
        m_parity = '0;
        for (int i = 0; i < OUT_W/8; i++) begin
            m_parity[i] = ^m_data[8*i +: 8];
        end
    end
`endif

endmodule
